// File: rtl/sprite_anim_engine.sv
// Pipelined sprite renderer: tear-free position, sprite ROM addressing with mirror, and frame animation.
// Colour/valid appear exactly two pixel clocks after the raster coordinate that produced them.
module sprite_anim_engine #(
  parameter int unsigned SPR_W       = 32,
  parameter int unsigned SPR_H       = 32,
  parameter int unsigned COLOR_W     = 3,
  parameter int unsigned NUM_FRAMES  = 4,
  parameter int unsigned FRAME_TICKS = 8,
  parameter int unsigned H_MAX       = 640,
  parameter int unsigned V_MAX       = 480
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [9:0]                                      hcount,
  input  logic [9:0]                                      vcount,
  input  logic                                            frame_start,
  input  logic                                            pos_load,
  input  logic [9:0]                                      new_h,
  input  logic [9:0]                                      new_v,
  input  logic [1:0]                                      sprite_selec,
  input  logic                                            flip_h,
  input  logic                                            anim_en,
  input  logic                                            bounds_draw,
  output logic [1+$clog2(NUM_FRAMES*SPR_H*SPR_W):0]       rom_addr,
  input  logic [COLOR_W-1:0]                              rom_data,
  output logic [COLOR_W-1:0]                              pix_color,
  output logic                                            pix_valid,
  output logic [$clog2(NUM_FRAMES)-1:0]                   frame_idx
);

  localparam int unsigned ROW_W   = $clog2(SPR_H);
  localparam int unsigned COL_W   = $clog2(SPR_W);
  localparam int unsigned FRAME_W = $clog2(NUM_FRAMES);
  localparam int unsigned ADDR_W  = 2 + FRAME_W + ROW_W + COL_W;
  localparam int unsigned TICK_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned H_LIM   = H_MAX - SPR_W;
  localparam int unsigned V_LIM   = V_MAX - SPR_H;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [FRAME_W-1:0]  frame_idx_q, frame_idx_d;
  logic [TICK_W-1:0]   ticks_q, ticks_d;
  logic [1:0]          pause_sel_q, pause_sel_d;

  logic [9:0]          shadow_h_q, shadow_h_d, shadow_v_q, shadow_v_d;
  logic [9:0]          act_h_q, act_h_d, act_v_q, act_v_d;

  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                hit_d1_q, hit_d2_q;

  logic [9:0]          h_clamp, v_clamp;
  logic [10:0]         h_ext, v_ext, ah_ext, av_ext;
  logic                hit;
  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col_raw, col;

  // Shadow position is clamped on load; frame_start commits it (including a same-cycle load).
  always_comb begin
    h_clamp    = ({1'b0, new_h} > 11'(H_LIM)) ? 10'(H_LIM) : new_h;
    v_clamp    = ({1'b0, new_v} > 11'(V_LIM)) ? 10'(V_LIM) : new_v;
    shadow_h_d = pos_load ? h_clamp : shadow_h_q;
    shadow_v_d = pos_load ? v_clamp : shadow_v_q;
    act_h_d    = frame_start ? shadow_h_d : act_h_q;
    act_v_d    = frame_start ? shadow_v_d : act_v_q;
  end

  // Stage 0: hit test at 11 bits so act+SPR_W never wraps, then form the ROM address.
  always_comb begin
    h_ext   = {1'b0, hcount};
    v_ext   = {1'b0, vcount};
    ah_ext  = {1'b0, act_h_q};
    av_ext  = {1'b0, act_v_q};
    hit     = bounds_draw
              && (h_ext >= ah_ext) && (h_ext < ah_ext + 11'(SPR_W))
              && (v_ext >= av_ext) && (v_ext < av_ext + 11'(SPR_H));
    row     = ROW_W'(vcount - act_v_q);
    col_raw = COL_W'(hcount - act_h_q);
    col     = flip_h ? (COL_W'(SPR_W - 1) - col_raw) : col_raw;
    rom_addr_d = hit ? {sprite_selec, frame_idx_q, row, col} : '0;
  end

  // Animation FSM; every transition and counter update is gated by frame_start.
  always_comb begin
    state_d     = state_q;
    frame_idx_d = frame_idx_q;
    ticks_d     = ticks_q;
    pause_sel_d = pause_sel_q;
    if (frame_start) begin
      if (anim_en) begin
        state_d = S_RUN;
        if (ticks_q == TICK_W'(FRAME_TICKS - 1)) begin
          ticks_d     = '0;
          frame_idx_d = frame_idx_q + FRAME_W'(1);
        end else begin
          ticks_d = ticks_q + TICK_W'(1);
        end
      end else begin
        case (state_q)
          S_RUN: begin
            state_d     = S_PAUSE;
            pause_sel_d = sprite_selec;
          end
          S_PAUSE: begin
            if (sprite_selec != pause_sel_q) begin
              state_d     = S_IDLE;
              frame_idx_d = '0;
              ticks_d     = '0;
            end
          end
          default: begin
            state_d     = S_IDLE;
            frame_idx_d = '0;
            ticks_d     = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      frame_idx_q <= '0;
      ticks_q     <= '0;
      pause_sel_q <= '0;
      shadow_h_q  <= '0;
      shadow_v_q  <= '0;
      act_h_q     <= '0;
      act_v_q     <= '0;
      rom_addr_q  <= '0;
      hit_d1_q    <= 1'b0;
      hit_d2_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_idx_q <= frame_idx_d;
      ticks_q     <= ticks_d;
      pause_sel_q <= pause_sel_d;
      shadow_h_q  <= shadow_h_d;
      shadow_v_q  <= shadow_v_d;
      act_h_q     <= act_h_d;
      act_v_q     <= act_v_d;
      rom_addr_q  <= rom_addr_d;
      hit_d1_q    <= hit;
      hit_d2_q    <= hit_d1_q;
    end
  end

  // The ROM's output register is the stage-2 pipeline register; qualify it here to hold 2-clk latency.
  assign rom_addr  = rom_addr_q;
  assign frame_idx = frame_idx_q;
  assign pix_valid = hit_d2_q & (rom_data != '0);
  assign pix_color = pix_valid ? rom_data : '0;

endmodule

// File: tb/tb_sprite_anim_engine.sv
// Bench for sprite_anim_engine: directed vector table, hand sequences for position/animation/reset,
// and a randomized run against an arithmetic reference model with a synchronous ROM model.
module tb_sprite_anim_engine;

  localparam int FT = 2;
  localparam int NF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] hcount, vcount, new_h, new_v;
  logic       frame_start, pos_load, flip_h, anim_en, bounds_draw;
  logic [1:0] sprite_selec;
  logic [13:0] rom_addr;
  logic [2:0] rom_data, pix_color;
  logic       pix_valid;
  logic [1:0] frame_idx;

  logic [2:0] mem [16384];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_sh_h, m_sh_v, m_act_h, m_act_v, m_count, m_mode, m_psel;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       flip;
    logic       bd;
    logic [1:0] sel;
    int         exp_addr;
    int         exp_color;
    string      name;
  } vec_t;

  vec_t tv[10];
  int t5_exp[12];

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= mem[rom_addr];

  sprite_anim_engine #(.FRAME_TICKS(FT)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .frame_start(frame_start), .pos_load(pos_load), .new_h(new_h), .new_v(new_v),
    .sprite_selec(sprite_selec), .flip_h(flip_h), .anim_en(anim_en), .bounds_draw(bounds_draw),
    .rom_addr(rom_addr), .rom_data(rom_data), .pix_color(pix_color), .pix_valid(pix_valid),
    .frame_idx(frame_idx)
  );

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    hcount = '0; vcount = '0; bounds_draw = 1'b0; flip_h = 1'b0; sprite_selec = 2'd0;
  endtask

  task automatic probe(input vec_t t);
    drive_idle();
    tick();
    tick();
    hcount = t.h; vcount = t.v; flip_h = t.flip; bounds_draw = t.bd; sprite_selec = t.sel;
    tick();
    chk({t.name, "_addr"}, int'(rom_addr), t.exp_addr);
    chk({t.name, "_early"}, int'(pix_valid), 0);
    drive_idle();
    tick();
    chk({t.name, "_color"}, int'(pix_color), t.exp_color);
    chk({t.name, "_valid"}, int'(pix_valid), (t.exp_color != 0) ? 1 : 0);
  endtask

  task automatic load_pos(input int h, input int v, input logic fs);
    pos_load = 1'b1; new_h = 10'(h); new_v = 10'(v); frame_start = fs;
    tick();
    pos_load = 1'b0; frame_start = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  function automatic vec_t mk(input int h, input int v, input int addr, input int color, input string nm);
    vec_t r;
    r.h = 10'(h); r.v = 10'(v); r.flip = 1'b0; r.bd = 1'b1; r.sel = 2'd0;
    r.exp_addr = addr; r.exp_color = color; r.name = nm;
    return r;
  endfunction

  function automatic int m_frame();
    return (m_count / FT) % NF;
  endfunction

  // Expected address/colour for the raster inputs currently applied.
  task automatic expect_now(output int a, output int c);
    int h, v, row, col;
    h = int'(hcount); v = int'(vcount);
    if (bounds_draw && h >= m_act_h && h < m_act_h + 32 && v >= m_act_v && v < m_act_v + 32) begin
      row = v - m_act_v;
      col = h - m_act_h;
      if (flip_h) col = 31 - col;
      a = int'(sprite_selec) * 4096 + m_frame() * 1024 + row * 32 + col;
      c = int'(mem[a]);
    end else begin
      a = 0;
      c = 0;
    end
  endtask

  // Model update for one clock edge using the inputs held across it.
  task automatic model_edge();
    if (pos_load) begin
      m_sh_h = (int'(new_h) > 608) ? 608 : int'(new_h);
      m_sh_v = (int'(new_v) > 448) ? 448 : int'(new_v);
    end
    if (frame_start) begin
      m_act_h = m_sh_h;
      m_act_v = m_sh_v;
      if (anim_en) begin
        m_mode = 1;
        m_count++;
      end else if (m_mode == 1) begin
        m_mode = 2;
        m_psel = int'(sprite_selec);
      end else if (m_mode == 2) begin
        if (int'(sprite_selec) != m_psel) begin
          m_mode = 0;
          m_count = 0;
        end
      end else begin
        m_count = 0;
      end
    end
  endtask

  initial begin
    int ca, cc, p1a, p1c, p2a, p2c;
    bit p1v, p2v;

    drive_idle();
    frame_start = 1'b0; pos_load = 1'b0; new_h = '0; new_v = '0; anim_en = 1'b0;
    for (int i = 0; i < 16384; i++) mem[i] = 3'($urandom);
    mem[0] = 3'd3; mem[1] = 3'd2; mem[32] = 3'd0; mem[33] = 3'd6; mem[63] = 3'd7;
    mem[1023] = 3'd5; mem[8193] = 3'd4; mem[1057] = 3'd6;

    tv[0] = mk(150, 390, 0, 3, "t1_origin");
    tv[1] = mk(182, 390, 0, 0, "t2_right_out");
    tv[2] = mk(150, 422, 0, 0, "t2_bottom_out");
    tv[3] = mk(181, 421, 1023, 5, "t2_last_pixel");
    tv[4] = mk(150, 391, 32, 0, "t2_transparent");
    tv[5] = mk(150, 391, 63, 7, "t3_flip");
    tv[5].flip = 1'b1;
    tv[6] = mk(160, 400, 0, 0, "bounds_off");
    tv[6].bd = 1'b0;
    tv[7] = mk(151, 390, 8193, 4, "bank2");
    tv[7].sel = 2'd2;
    tv[8] = mk(149, 390, 0, 0, "left_out");
    tv[9] = mk(150, 389, 0, 0, "top_out");
    t5_exp = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1, 1, 2};

    // Reset state
    tick();
    tick();
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_valid", int'(pix_valid), 0);
    chk("rst_frame", int'(frame_idx), 0);
    reset = 1'b1;
    tick();

    // T1-T3: vector table at (150,390)
    load_pos(150, 390, 1'b0);
    pulse_fs();
    for (int i = 0; i < 10; i++) probe(tv[i]);

    // T4: shadow/active position
    load_pos(300, 100, 1'b0);
    probe(mk(151, 390, 1, 2, "t4_old_pos"));
    probe(mk(301, 100, 0, 0, "t4_not_yet"));
    pulse_fs();
    probe(mk(301, 100, 1, 2, "t4_new_pos"));
    probe(mk(151, 390, 0, 0, "t4_old_gone"));
    load_pos(700, 470, 1'b1);
    probe(mk(609, 449, 33, 6, "t4_clamped"));
    probe(mk(639, 479, 1023, 5, "t4_clamp_corner"));

    // T5: animation run / pause / resume / idle on bank change
    anim_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      pulse_fs();
      chk($sformatf("t5_run%0d", k + 1), int'(frame_idx), t5_exp[k]);
    end
    anim_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      pulse_fs();
      chk($sformatf("t5_hold%0d", k), int'(frame_idx), 2);
    end
    anim_en = 1'b1;
    pulse_fs();
    chk("t5_resume_a", int'(frame_idx), 2);
    tick();
    chk("t5_no_midframe", int'(frame_idx), 2);
    pulse_fs();
    chk("t5_resume_b", int'(frame_idx), 3);
    anim_en = 1'b0;
    pulse_fs();
    chk("t5_pause", int'(frame_idx), 3);
    sprite_selec = 2'd1;
    pulse_fs();
    chk("t5_bank_idle", int'(frame_idx), 0);
    sprite_selec = 2'd0;

    // T6: asynchronous reset mid-line while drawing
    anim_en = 1'b1;
    pulse_fs();
    pulse_fs();
    chk("t6_frame_pre", int'(frame_idx), 1);
    anim_en = 1'b0;
    hcount = 10'd609; vcount = 10'd449; bounds_draw = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_addr_pre", int'(rom_addr), 1057);
    chk("t6_valid_pre", int'(pix_valid), 1);
    chk("t6_color_pre", int'(pix_color), 6);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", int'(pix_valid), 0);
    chk("t6_async_color", int'(pix_color), 0);
    chk("t6_async_addr", int'(rom_addr), 0);
    chk("t6_async_frame", int'(frame_idx), 0);
    tick();
    reset = 1'b1;
    drive_idle();
    anim_en = 1'b1;
    pulse_fs();
    chk("t6_idle_a", int'(frame_idx), 0);
    pulse_fs();
    chk("t6_idle_b", int'(frame_idx), 1);
    anim_en = 1'b0;

    // Randomized run against the reference model
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_sh_h = 0; m_sh_v = 0; m_act_h = 0; m_act_v = 0; m_count = 0; m_mode = 0; m_psel = 0;
    p1v = 1'b0; p2v = 1'b0; p1a = 0; p1c = 0; p2a = 0; p2c = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        hcount = 10'(m_act_h + int'($urandom_range(0, 40)) - 4);
        vcount = 10'(m_act_v + int'($urandom_range(0, 40)) - 4);
      end else begin
        hcount = 10'($urandom);
        vcount = 10'($urandom);
      end
      flip_h      = 1'($urandom);
      bounds_draw = ($urandom_range(0, 9) != 0);
      frame_start = ($urandom_range(0, 15) == 0);
      pos_load    = ($urandom_range(0, 29) == 0);
      new_h       = 10'($urandom);
      new_v       = 10'($urandom);
      if ($urandom_range(0, 39) == 0) anim_en = ~anim_en;
      if ($urandom_range(0, 59) == 0) sprite_selec = 2'($urandom);
      expect_now(ca, cc);
      @(posedge clk);
      model_edge();
      p2v = p1v; p2a = p1a; p2c = p1c;
      p1v = 1'b1; p1a = ca; p1c = cc;
      @(negedge clk);
      if (p1v) chk($sformatf("rnd%0d_addr", i), int'(rom_addr), p1a);
      if (p2v) begin
        chk($sformatf("rnd%0d_color", i), int'(pix_color), p2c);
        chk($sformatf("rnd%0d_valid", i), int'(pix_valid), (p2c != 0) ? 1 : 0);
      end
      chk($sformatf("rnd%0d_frame", i), int'(frame_idx), m_frame());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
